// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike integration with leak,
// threshold firing and a fixed refractory period.
module lif_neuron #(
    parameter int unsigned NUM_INPUTS   = 4,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned POT_WIDTH    = 16,
    parameter int unsigned THRESHOLD    = 100,
    parameter int unsigned LEAK         = 1,
    parameter int unsigned REFRACTORY   = 3
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  en,
    input  logic [NUM_INPUTS-1:0]                                 spike_in,
    input  logic                                                  weight_we,
    input  logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] weight_addr,
    input  logic [WEIGHT_WIDTH-1:0]                               weight_din,
    output logic                                                  spike_out,
    output logic [POT_WIDTH-1:0]                                  potential,
    output logic                                                  refractory
);

    localparam int unsigned SUM_W = WEIGHT_WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int unsigned NXT_W = ((POT_WIDTH > SUM_W) ? POT_WIDTH : SUM_W) + 2;
    localparam int unsigned CNT_W = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [POT_WIDTH-1:0]            pot_d;
    logic                            spike_d;
    logic                            refr_d;
    logic signed [WEIGHT_WIDTH-1:0]  weight [NUM_INPUTS];
    logic signed [SUM_W-1:0]         syn_sum;
    logic signed [NXT_W-1:0]         pot_raw;
    logic [POT_WIDTH-1:0]            pot_clamped;

    // Synaptic weight file; writes land regardless of en or state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                weight[i] <= '0;
            end
        end else if (weight_we && (32'(weight_addr) < NUM_INPUTS)) begin
            weight[weight_addr] <= weight_din;
        end
    end

    // Signed sum of the weights of all active inputs.
    always_comb begin
        syn_sum = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (spike_in[i]) begin
                syn_sum = syn_sum + SUM_W'(weight[i]);
            end
        end
    end

    // Candidate potential at full signed width, then saturated to the register range.
    always_comb begin
        pot_raw = signed'(NXT_W'(potential)) + NXT_W'(syn_sum) - signed'(NXT_W'(LEAK));
        if (pot_raw[NXT_W-1]) begin
            pot_clamped = '0;
        end else if (|pot_raw[NXT_W-2:POT_WIDTH]) begin
            pot_clamped = '1;
        end else begin
            pot_clamped = pot_raw[POT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pot_d   = potential;
        spike_d = 1'b0;
        refr_d  = refractory;
        if (en) begin
            unique case (state_q)
                INTEGRATE: begin
                    if (pot_clamped >= POT_WIDTH'(THRESHOLD)) begin
                        pot_d   = '0;
                        spike_d = 1'b1;
                        state_d = REFRACT;
                        cnt_d   = CNT_W'(REFRACTORY - 1);
                        refr_d  = 1'b1;
                    end else begin
                        pot_d = pot_clamped;
                    end
                end
                REFRACT: begin
                    pot_d = '0;
                    if (cnt_q == '0) begin
                        state_d = INTEGRATE;
                        refr_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = INTEGRATE;
                    refr_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INTEGRATE;
            cnt_q      <= '0;
            potential  <= '0;
            spike_out  <= 1'b0;
            refractory <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            potential  <= pot_d;
            spike_out  <= spike_d;
            refractory <= refr_d;
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: integer reference model compared every cycle,
// directed literal checks followed by randomized traffic.
module tb_lif_neuron;

    localparam int NI = 4;
    localparam int WW = 8;
    localparam int PW = 16;
    localparam int TH = 100;
    localparam int LK = 1;
    localparam int RF = 3;
    localparam int POT_MAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [NI-1:0] spike_in = '0;
    logic          weight_we = 1'b0;
    logic [1:0]    weight_addr = '0;
    logic [WW-1:0] weight_din = '0;
    logic          spike_out;
    logic [PW-1:0] potential;
    logic          refractory;

    int total = 0;
    int bad = 0;
    bit check_on = 1'b0;

    // reference model state: potential, remaining refractory cycles, weights
    int m_pot = 0;
    int m_left = 0;
    int m_w [NI];
    bit m_spike = 1'b0;
    int m_sum;
    int m_nxt;

    always #5 clk = ~clk;

    lif_neuron #(
        .NUM_INPUTS  (NI),
        .WEIGHT_WIDTH(WW),
        .POT_WIDTH   (PW),
        .THRESHOLD   (TH),
        .LEAK        (LK),
        .REFRACTORY  (RF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .weight_we  (weight_we),
        .weight_addr(weight_addr),
        .weight_din (weight_din),
        .spike_out  (spike_out),
        .potential  (potential),
        .refractory (refractory)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step per rising edge, cleared by reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pot = 0;
            m_left = 0;
            m_spike = 1'b0;
            for (int i = 0; i < NI; i++) m_w[i] = 0;
        end else begin
            m_sum = 0;
            for (int i = 0; i < NI; i++) if (spike_in[i]) m_sum += m_w[i];
            m_spike = 1'b0;
            if (en) begin
                if (m_left > 0) begin
                    m_left--;
                    m_pot = 0;
                end else begin
                    m_nxt = m_pot + m_sum - LK;
                    if (m_nxt < 0) m_nxt = 0;
                    if (m_nxt > POT_MAX) m_nxt = POT_MAX;
                    if (m_nxt >= TH) begin
                        m_pot = 0;
                        m_spike = 1'b1;
                        m_left = RF;
                    end else begin
                        m_pot = m_nxt;
                    end
                end
            end
            if (weight_we && int'(weight_addr) < NI)
                m_w[weight_addr] = int'($signed(weight_din));
        end
    end

    always @(posedge clk or negedge rst) begin
        #2;
        if (check_on) begin
            chk("model_spike", int'(spike_out), int'(m_spike));
            chk("model_pot", int'(potential), m_pot);
            chk("model_refr", int'(refractory), int'(m_left > 0));
        end
    end

    task automatic cyc(input logic [NI-1:0] sp, input bit we = 1'b0,
                       input int a = 0, input int d = 0);
        spike_in = sp;
        weight_we = we;
        weight_addr = 2'(a);
        weight_din = 8'(d);
        @(negedge clk);
        weight_we = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pot", int'(potential), 0);
        chk("rst_spike", int'(spike_out), 0);
        chk("rst_refr", int'(refractory), 0);
        rst = 1'b1;
        en = 1'b1;
        check_on = 1'b1;

        cyc(4'b1111);                 chk("zero_weights", int'(potential), 0);
        cyc(4'b0000, 1'b1, 0, 30);    chk("wr_w0", int'(potential), 0);
        cyc(4'b0001);                 chk("fire_p1", int'(potential), 29);
        cyc(4'b0001);                 chk("fire_p2", int'(potential), 58);
        cyc(4'b0001);                 chk("fire_p3", int'(potential), 87);
        cyc(4'b0001);
        chk("fire_spike", int'(spike_out), 1);
        chk("fire_pot0", int'(potential), 0);
        chk("fire_refr", int'(refractory), 1);
        cyc(4'b0001);
        chk("refr2_spike", int'(spike_out), 0);
        chk("refr2", int'(refractory), 1);
        cyc(4'b0001);                 chk("refr3", int'(refractory), 1);
        cyc(4'b0001);
        chk("refr_end", int'(refractory), 0);
        chk("refr_end_pot", int'(potential), 0);
        cyc(4'b0001);                 chk("resume", int'(potential), 29);

        cyc(4'b0000, 1'b1, 1, -50);   chk("inh_wr", int'(potential), 28);
        cyc(4'b0010);                 chk("inh_clamp", int'(potential), 0);
        cyc(4'b0011);                 chk("inh_clamp2", int'(potential), 0);

        cyc(4'b0001);
        cyc(4'b0001);                 chk("leak_start", int'(potential), 58);
        cyc(4'b0000);                 chk("leak_57", int'(potential), 57);
        cyc(4'b0000);                 chk("leak_56", int'(potential), 56);
        repeat (60) cyc(4'b0000);     chk("leak_floor", int'(potential), 0);
        cyc(4'b0000);                 chk("leak_hold", int'(potential), 0);

        repeat (4) cyc(4'b0001);      chk("frz_fire", int'(spike_out), 1);
        cyc(4'b0001);                 chk("frz_cnt1", int'(refractory), 1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0001);
            chk("frz_refr", int'(refractory), 1);
            chk("frz_pot", int'(potential), 0);
            chk("frz_spike", int'(spike_out), 0);
        end
        en = 1'b1;
        cyc(4'b0001);                 chk("frz_after1", int'(refractory), 1);
        cyc(4'b0001);                 chk("frz_after2", int'(refractory), 0);
        cyc(4'b0001);                 chk("frz_resume", int'(potential), 29);

        repeat (40) cyc(4'b0000);     chk("col_idle", int'(potential), 0);
        cyc(4'b0100, 1'b1, 2, 120);
        chk("col_old_w", int'(potential), 0);
        chk("col_no_spike", int'(spike_out), 0);
        cyc(4'b0100);
        chk("col_spike", int'(spike_out), 1);
        chk("col_refr", int'(refractory), 1);
        rst = 1'b0;
        #1;
        chk("arst_refr", int'(refractory), 0);
        chk("arst_spike", int'(spike_out), 0);
        chk("arst_pot", int'(potential), 0);
        cyc(4'b1111, 1'b1, 0, 100);
        chk("rst_hold_refr", int'(refractory), 0);
        chk("rst_hold_pot", int'(potential), 0);
        rst = 1'b1;
        cyc(4'b0101, 1'b1, 0, 50);    chk("post_rst_zero", int'(potential), 0);
        chk("post_rst_integ", int'(refractory), 0);
        cyc(4'b0001);                 chk("post_rst_w", int'(potential), 49);

        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(9) != 0);
            if ($urandom_range(299) == 0) begin
                rst = 1'b0;
                #3;
                rst = 1'b1;
            end
            cyc(4'($urandom), ($urandom_range(7) == 0), int'($urandom_range(3)),
                int'($urandom_range(120)) - 50);
        end

        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
